// File: rtl/cart_mem_pkg.sv
// Shared types and default SDRAM region bases for the cartridge memory port.
// Owner codes double as the arbiter's visible owner output.
package cart_mem_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_PRG  = 2'd1,
      OWN_WRAM = 2'd2,
      OWN_CHR  = 2'd3
   } owner_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   // WRAM sits above the region the EEPROM loader initialises.
   localparam logic [20:0] DEF_PRG_BASE  = 21'h000000;
   localparam logic [20:0] DEF_CHR_BASE  = 21'h008000;
   localparam logic [20:0] DEF_WRAM_BASE = 21'h010000;

endpackage

// File: rtl/sdram_req_picker.sv
// Combinational winner selection: PRG > WRAM > CHR, unless CHR has been
// starved long enough, in which case a pending CHR request wins outright.
module sdram_req_picker
   import cart_mem_pkg::*;
(
   input  logic   prg_req,
   input  logic   wram_req,
   input  logic   chr_req,
   input  logic   starve_full,
   output owner_t winner
);

   always_comb begin
      winner = OWN_NONE;
      if (chr_req && starve_full) begin
         winner = OWN_CHR;
      end else if (prg_req) begin
         winner = OWN_PRG;
      end else if (wram_req) begin
         winner = OWN_WRAM;
      end else if (chr_req) begin
         winner = OWN_CHR;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Single-outstanding scheduler sharing SDRAM port 1 between PRG fetch,
// WRAM read/write and CHR window refill, with CHR starvation promotion.
module sdram_port_arbiter
   import cart_mem_pkg::*;
#(
   parameter int                ADDR_W       = 21,
   parameter logic [ADDR_W-1:0] PRG_BASE     = ADDR_W'(DEF_PRG_BASE),
   parameter logic [ADDR_W-1:0] CHR_BASE     = ADDR_W'(DEF_CHR_BASE),
   parameter logic [ADDR_W-1:0] WRAM_BASE    = ADDR_W'(DEF_WRAM_BASE),
   parameter int                STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_init_done,
   input  logic              prg_req,
   input  logic [14:0]       prg_addr,
   output logic              prg_ack,
   output logic              prg_ready,
   output logic [7:0]        prg_data,
   input  logic              wram_req,
   input  logic              wram_wren,
   input  logic [12:0]       wram_addr,
   input  logic [7:0]        wram_wdata,
   output logic              wram_ack,
   output logic              wram_ready,
   output logic [7:0]        wram_rdata,
   input  logic              chr_req,
   input  logic [14:0]       chr_addr,
   output logic              chr_ack,
   output logic              chr_ready,
   output logic [7:0]        chr_data,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_wren,
   output logic [7:0]        to_mem,
   input  logic [7:0]        from_mem,
   input  logic              mem_ready,
   output logic              busy,
   output logic [1:0]        owner
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
   localparam bit BASES_ALIGNED = (PRG_BASE[14:0] == 15'd0) &&
                                  (CHR_BASE[14:0] == 15'd0) &&
                                  (WRAM_BASE[12:0] == 13'd0);

   state_t           state;
   owner_t           owner_q;
   owner_t           winner;
   logic [CNT_W-1:0] starve_cnt;
   logic             starve_full;
   logic             any_req;

   assign starve_full = (starve_cnt >= CNT_MAX);
   assign any_req     = prg_req || wram_req || chr_req;
   assign owner       = owner_q;

   sdram_req_picker u_picker (
      .prg_req     (prg_req),
      .wram_req    (wram_req),
      .chr_req     (chr_req),
      .starve_full (starve_full),
      .winner      (winner)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         owner_q     <= OWN_NONE;
         starve_cnt  <= '0;
         busy        <= 1'b0;
         mem_req     <= 1'b0;
         mem_address <= '0;
         mem_wren    <= 1'b0;
         to_mem      <= 8'h00;
         prg_ack     <= 1'b0;
         wram_ack    <= 1'b0;
         chr_ack     <= 1'b0;
         prg_ready   <= 1'b0;
         wram_ready  <= 1'b0;
         chr_ready   <= 1'b0;
         prg_data    <= 8'h00;
         wram_rdata  <= 8'h00;
         chr_data    <= 8'h00;
      end else begin
         mem_req    <= 1'b0;
         prg_ack    <= 1'b0;
         wram_ack   <= 1'b0;
         chr_ack    <= 1'b0;
         prg_ready  <= 1'b0;
         wram_ready <= 1'b0;
         chr_ready  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mem_init_done && any_req) begin
                  owner_q <= winner;
                  busy    <= 1'b1;
                  mem_req <= 1'b1;
                  state   <= ST_ISSUE;
                  case (winner)
                     OWN_PRG: begin
                        mem_address <= PRG_BASE | ADDR_W'(prg_addr);
                        mem_wren    <= 1'b0;
                        prg_ack     <= 1'b1;
                     end
                     OWN_WRAM: begin
                        mem_address <= WRAM_BASE | ADDR_W'(wram_addr);
                        mem_wren    <= wram_wren;
                        to_mem      <= wram_wdata;
                        wram_ack    <= 1'b1;
                     end
                     OWN_CHR: begin
                        mem_address <= CHR_BASE | ADDR_W'(chr_addr);
                        mem_wren    <= 1'b0;
                        chr_ack     <= 1'b1;
                     end
                     default: ;
                  endcase
                  // Losses only count while CHR is actually asking.
                  if (winner == OWN_CHR) begin
                     starve_cnt <= '0;
                  end else if (chr_req && !starve_full) begin
                     starve_cnt <= starve_cnt + CNT_W'(1);
                  end
               end
            end
            ST_ISSUE: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_ready) begin
                  case (owner_q)
                     OWN_PRG: begin
                        prg_data  <= from_mem;
                        prg_ready <= 1'b1;
                     end
                     OWN_WRAM: begin
                        if (!mem_wren) begin
                           wram_rdata <= from_mem;
                        end
                        wram_ready <= 1'b1;
                     end
                     OWN_CHR: begin
                        chr_data  <= from_mem;
                        chr_ready <= 1'b1;
                     end
                     default: ;
                  endcase
                  state   <= ST_IDLE;
                  owner_q <= OWN_NONE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // A completion with nothing outstanding means the controller and arbiter disagree.
   a_spurious_ready: assert property (@(posedge clk) disable iff (!rst_n)
      mem_ready |-> (state == ST_WAIT))
      else $error("sdram_port_arbiter: mem_ready outside WAIT ignored");

   a_base_align: assert property (@(posedge clk) disable iff (!rst_n) BASES_ALIGNED)
      else $error("sdram_port_arbiter: region base parameter misaligned");

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: the bench plays the SDRAM controller
// and checks grants, addresses, data capture, starvation and reset behaviour.
module tb_sdram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_init_done = 1'b0;
   logic        prg_req = 1'b0;
   logic [14:0] prg_addr = '0;
   logic        prg_ack, prg_ready;
   logic [7:0]  prg_data;
   logic        wram_req = 1'b0;
   logic        wram_wren = 1'b0;
   logic [12:0] wram_addr = '0;
   logic [7:0]  wram_wdata = '0;
   logic        wram_ack, wram_ready;
   logic [7:0]  wram_rdata;
   logic        chr_req = 1'b0;
   logic [14:0] chr_addr = '0;
   logic        chr_ack, chr_ready;
   logic [7:0]  chr_data;
   logic        mem_req;
   logic [20:0] mem_address;
   logic        mem_wren;
   logic [7:0]  to_mem;
   logic [7:0]  from_mem = '0;
   logic        mem_ready = 1'b0;
   logic        busy;
   logic [1:0]  owner;

   int checks = 0;
   int failures = 0;

   sdram_port_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_init_done (mem_init_done),
      .prg_req       (prg_req),
      .prg_addr      (prg_addr),
      .prg_ack       (prg_ack),
      .prg_ready     (prg_ready),
      .prg_data      (prg_data),
      .wram_req      (wram_req),
      .wram_wren     (wram_wren),
      .wram_addr     (wram_addr),
      .wram_wdata    (wram_wdata),
      .wram_ack      (wram_ack),
      .wram_ready    (wram_ready),
      .wram_rdata    (wram_rdata),
      .chr_req       (chr_req),
      .chr_addr      (chr_addr),
      .chr_ack       (chr_ack),
      .chr_ready     (chr_ready),
      .chr_data      (chr_data),
      .mem_req       (mem_req),
      .mem_address   (mem_address),
      .mem_wren      (mem_wren),
      .to_mem        (to_mem),
      .from_mem      (from_mem),
      .mem_ready     (mem_ready),
      .busy          (busy),
      .owner         (owner)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Plays the controller: completes the outstanding access after lat extra cycles.
   // Called on the negedge where the grant is visible; returns on the negedge
   // where the owner's ready pulse should be visible.
   task automatic applyStimulus(input logic [7:0] data, input int lat);
      repeat (1 + lat) @(negedge clk);
      mem_ready = 1'b1;
      from_mem  = data;
      @(negedge clk);
      mem_ready = 1'b0;
      from_mem  = 8'h00;
   endtask

   task automatic waitGrant(input string tag);
      int n = 0;
      @(negedge clk);
      while (!(prg_ack || wram_ack || chr_ack) && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_grant_seen"}, 32'(prg_ack || wram_ack || chr_ack), 32'd1);
   endtask

   initial begin
      int seen;

      // Reset state
      @(negedge clk);
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_owner", 32'(owner), 32'd0);
      checkOutput("rst_acks", 32'({prg_ack, wram_ack, chr_ack}), 32'd0);
      checkOutput("rst_readys", 32'({prg_ready, wram_ready, chr_ready}), 32'd0);
      checkOutput("rst_data", 32'({prg_data, wram_rdata, chr_data}), 32'd0);
      checkOutput("rst_mem_address", 32'(mem_address), 32'd0);
      checkOutput("rst_wren_to_mem", 32'({mem_wren, to_mem}), 32'd0);
      rst_n = 1'b1;

      // No grants while the EEPROM load is incomplete
      prg_req  = 1'b1;
      prg_addr = 15'h0123;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_req || prg_ack) seen++;
      end
      checkOutput("uninit_no_grant", 32'(seen), 32'd0);

      mem_init_done = 1'b1;
      @(negedge clk);
      checkOutput("prg1_mem_req", 32'(mem_req), 32'd1);
      checkOutput("prg1_ack", 32'(prg_ack), 32'd1);
      checkOutput("prg1_address", 32'(mem_address), 32'h000123);
      checkOutput("prg1_owner", 32'(owner), 32'd1);
      checkOutput("prg1_busy", 32'(busy), 32'd1);
      checkOutput("prg1_wren", 32'(mem_wren), 32'd0);
      prg_req = 1'b0;
      @(negedge clk);
      checkOutput("prg1_req_pulse", 32'({mem_req, prg_ack}), 32'd0);
      checkOutput("prg1_busy_wait", 32'(busy), 32'd1);
      mem_ready = 1'b1;
      from_mem  = 8'h3C;
      @(negedge clk);
      mem_ready = 1'b0;
      checkOutput("prg1_ready", 32'(prg_ready), 32'd1);
      checkOutput("prg1_data", 32'(prg_data), 32'h3C);
      checkOutput("prg1_others_data", 32'({wram_rdata, chr_data}), 32'd0);
      checkOutput("prg1_idle_owner", 32'(owner), 32'd0);
      checkOutput("prg1_idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("prg1_ready_width", 32'(prg_ready), 32'd0);
      checkOutput("prg1_data_held", 32'(prg_data), 32'h3C);

      // All three at once: PRG, then WRAM, then CHR
      prg_req   = 1'b1;
      prg_addr  = 15'h0456;
      wram_req  = 1'b1;
      wram_wren = 1'b0;
      wram_addr = 13'h0010;
      chr_req   = 1'b1;
      chr_addr  = 15'h1234;
      waitGrant("all_prg");
      checkOutput("all_prg_ack", 32'({prg_ack, wram_ack, chr_ack}), 32'b100);
      checkOutput("all_prg_address", 32'(mem_address), 32'h000456);
      prg_req = 1'b0;
      applyStimulus(8'h11, 0);
      checkOutput("all_prg_data", 32'(prg_data), 32'h11);
      waitGrant("all_wram");
      checkOutput("all_wram_ack", 32'({prg_ack, wram_ack, chr_ack}), 32'b010);
      checkOutput("all_wram_address", 32'(mem_address), 32'h010010);
      checkOutput("all_wram_owner", 32'(owner), 32'd2);
      wram_req = 1'b0;
      applyStimulus(8'h22, 1);
      checkOutput("all_wram_ready", 32'(wram_ready), 32'd1);
      checkOutput("all_wram_rdata", 32'(wram_rdata), 32'h22);
      checkOutput("all_wram_prg_held", 32'(prg_data), 32'h11);
      waitGrant("all_chr");
      checkOutput("all_chr_ack", 32'({prg_ack, wram_ack, chr_ack}), 32'b001);
      checkOutput("all_chr_address", 32'(mem_address), 32'h009234);
      checkOutput("all_chr_owner", 32'(owner), 32'd3);
      chr_req = 1'b0;
      applyStimulus(8'h3C, 2);
      checkOutput("all_chr_ready", 32'(chr_ready), 32'd1);
      checkOutput("all_chr_data", 32'(chr_data), 32'h3C);
      checkOutput("all_chr_others", 32'({prg_data, wram_rdata}), 32'h1122);

      // WRAM write leaves the read register alone
      wram_req   = 1'b1;
      wram_wren  = 1'b1;
      wram_addr  = 13'h0005;
      wram_wdata = 8'hA5;
      waitGrant("wr");
      checkOutput("wr_ack", 32'(wram_ack), 32'd1);
      checkOutput("wr_wren", 32'(mem_wren), 32'd1);
      checkOutput("wr_to_mem", 32'(to_mem), 32'hA5);
      checkOutput("wr_address", 32'(mem_address), 32'h010005);
      wram_req = 1'b0;
      applyStimulus(8'hFF, 0);
      checkOutput("wr_ready", 32'(wram_ready), 32'd1);
      checkOutput("wr_rdata_unchanged", 32'(wram_rdata), 32'h22);
      wram_wren = 1'b0;

      // Starvation: CHR loses eight times, wins the ninth, then counts afresh
      prg_req  = 1'b1;
      prg_addr = 15'h0001;
      chr_req  = 1'b1;
      chr_addr = 15'h0002;
      for (int i = 1; i <= 10; i++) begin
         waitGrant($sformatf("starve%0d", i));
         checkOutput($sformatf("starve%0d_chr_ack", i), 32'(chr_ack), 32'(i == 9));
         checkOutput($sformatf("starve%0d_prg_ack", i), 32'(prg_ack), 32'(i != 9));
         applyStimulus(8'(8'h40 + i), 0);
      end
      checkOutput("starve_chr_data", 32'(chr_data), 32'h49);
      checkOutput("starve_prg_data", 32'(prg_data), 32'h4A);
      prg_req = 1'b0;
      chr_req = 1'b0;

      // Reset during WAIT aborts with no ready pulse
      @(negedge clk);
      prg_req  = 1'b1;
      prg_addr = 15'h0777;
      waitGrant("rstw");
      prg_req = 1'b0;
      @(negedge clk);
      checkOutput("rstw_in_wait", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rstw_busy", 32'(busy), 32'd0);
      checkOutput("rstw_owner", 32'(owner), 32'd0);
      checkOutput("rstw_address", 32'(mem_address), 32'd0);
      checkOutput("rstw_data", 32'({prg_data, wram_rdata, chr_data}), 32'd0);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (prg_ready || wram_ready || chr_ready) seen++;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (prg_ready || wram_ready || chr_ready || busy) seen++;
      end
      checkOutput("rstw_no_ready", 32'(seen), 32'd0);
      chr_req  = 1'b1;
      chr_addr = 15'h0001;
      waitGrant("post_rst");
      checkOutput("post_rst_ack", 32'(chr_ack), 32'd1);
      checkOutput("post_rst_address", 32'(mem_address), 32'h008001);
      chr_req = 1'b0;
      applyStimulus(8'h5A, 0);
      checkOutput("post_rst_data", 32'(chr_data), 32'h5A);
      checkOutput("post_rst_ready", 32'(chr_ready), 32'd1);

      // mem_init_done dropping mid-transaction: finish it, then grant nothing
      prg_req  = 1'b1;
      prg_addr = 15'h0100;
      waitGrant("drop");
      mem_init_done = 1'b0;
      applyStimulus(8'h77, 0);
      checkOutput("drop_ready", 32'(prg_ready), 32'd1);
      checkOutput("drop_data", 32'(prg_data), 32'h77);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (mem_req || prg_ack || busy) seen++;
      end
      checkOutput("drop_no_grant", 32'(seen), 32'd0);
      prg_req = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Shares the single-port cartridge SDRAM controller between three requesters: PRG-ROM fetch, CHR window refill, and battery-backed PRG-RAM (WRAM) read/write for mappers that carry it. It replaces ad-hoc per-mapper request muxing with one registered, single-outstanding scheduler. It sits between the mapper logic (PRG path, chr_rom_window, WRAM decode) and SDRAM_SP8_I port 1, all in the memory clock domain.

Parameters:
ADDR_W, 21, SDRAM byte address width
PRG_BASE, 21'h000000, PRG region base, 32 KiB aligned
CHR_BASE, 21'h008000, CHR region base, 32 KiB aligned
WRAM_BASE, 21'h010000, WRAM region base, 8 KiB aligned, outside the EEPROM init range
STARVE_LIMIT, 8, lost arbitrations before CHR is promoted to top priority

Ports:
clk  in  1  memory clock (clk_mem domain)
rst_n  in  1  reset
mem_init_done  in  1  SDRAM load from EEPROM complete; no grants while low
prg_req  in  1  level request, held until prg_ack
prg_addr  in  15  PRG offset
prg_ack  out  1  1-cycle grant pulse
prg_ready  out  1  1-cycle data-valid pulse
prg_data  out  8  read data, held until next PRG completion
wram_req  in  1  level request, held until wram_ack
wram_wren  in  1  1 = write
wram_addr  in  13  WRAM offset
wram_wdata  in  8  write data
wram_ack  out  1  grant pulse
wram_ready  out  1  completion pulse
wram_rdata  out  8  read data, held
chr_req  in  1  level request, held until chr_ack
chr_addr  in  15  CHR offset (window address low bits)
chr_ack  out  1  grant pulse
chr_ready  out  1  completion pulse
chr_data  out  8  read data, held
mem_req  out  1  1-cycle request to SDRAM controller
mem_address  out  ADDR_W  SDRAM address
mem_wren  out  1  write enable
to_mem  out  8  write data
from_mem  in  8  read data, valid with mem_ready
mem_ready  in  1  transaction complete
busy  out  1  transaction outstanding
owner  out  2  current owner code

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low. Every flop clears when rst_n goes low.
- Reset values:
  - all ack, ready and mem_req outputs 0
  - all data outputs 8'h00
  - mem_address 0, mem_wren 0, to_mem 0
  - busy 0, owner OWN_NONE
  - FSM IDLE, starve counter 0
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If mem_init_done=1 and any request is high, latch the winner's owner, address, wren and wdata, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_req=1 and the winner's ack=1 in the same cycle; busy=1.
  - Next state is WAIT.
- WAIT:
  - On mem_ready, capture from_mem into the owner's data register on reads only.
  - Pulse the owner's ready on the next cycle, which is also the cycle the FSM is back in IDLE.
  - WRAM writes pulse wram_ready and leave wram_rdata unchanged.
- Latency: request sampled at edge N, then ack/mem_req during cycle N+1, then ready 1 cycle after mem_ready.
- Minimum turnaround between two grants is 3 cycles plus the SDRAM latency.
- Priority: PRG > WRAM > CHR.
- Starvation:
  - The counter increments on each arbitration where chr_req=1 and CHR loses, saturating at STARVE_LIMIT.
  - When it reaches STARVE_LIMIT, CHR wins the next arbitration outright.
  - The counter clears when CHR is granted.
- Address formation: mem_address = BASE OR zero-extended offset. Bases are aligned, so no carry is possible. Misaligned bases are a parameter error, flagged by a simulation assertion.
- Owner codes: NONE=0, PRG=1, WRAM=2, CHR=3. Holding owner at NONE while idle is required.
- mem_ready in IDLE or ISSUE is spurious: ignore it and raise a simulation error.
- A request dropped before its ack is legal; it simply loses arbitration. Requests that change after ack have no effect.
- mem_init_done falling while busy: complete the current transaction, then grant nothing further.
- Reset mid-transaction aborts immediately with no ready pulse. The SDRAM controller shares the reset.

Decomposition:
- Package cart_mem_pkg holds:
  - owner enum (OWN_NONE/OWN_PRG/OWN_WRAM/OWN_CHR)
  - default region base constants
  - FSM state encoding
- One sub-module, sdram_req_picker: purely combinational priority plus starve-override selection. It returns the winner owner code.
- The top level owns the FSM, latches, counter and output registers.

Test Plan:
- mem_init_done=0, prg_req=1 for 20 cycles -> no mem_req, no prg_ack. Raise mem_init_done -> mem_req with mem_address=21'h000000|prg_addr.
- prg_req, wram_req, chr_req asserted together -> grant order PRG, WRAM, CHR. CHR mem_address=21'h008000|chr_addr, e.g. chr_addr=15'h1234 -> 21'h009234.
- WRAM write addr 13'h0005, wdata 8'hA5 -> mem_wren=1, to_mem=8'hA5, mem_address=21'h010005. wram_ready pulses; wram_rdata unchanged.
- prg_req held continuously with chr_req=1 and STARVE_LIMIT=8 -> CHR granted on the 9th arbitration, then the counter is 0.
- Read with from_mem=8'h3C on mem_ready -> the owner's data becomes 8'h3C and its ready pulses exactly 1 cycle after mem_ready. Other owners' data registers are unchanged.
- rst_n low during WAIT -> all outputs go to reset values asynchronously, no ready pulse. After release, a fresh request is granted normally.
